// File: rtl/rtc_bus_pkg.sv
// rtl/rtc_bus_pkg.sv - register map, control bit positions and BCD field limits for rtc_bus_responder
package rtc_bus_pkg;
   typedef logic [7:0] bcd_t;

   localparam logic [7:0] ADDR_CTRL = 8'h00;
   localparam logic [7:0] ADDR_SEC  = 8'h21;
   localparam logic [7:0] ADDR_MIN  = 8'h22;
   localparam logic [7:0] ADDR_HR   = 8'h23;
   localparam logic [7:0] ADDR_DAY  = 8'h24;
   localparam logic [7:0] ADDR_MON  = 8'h25;
   localparam logic [7:0] ADDR_YR   = 8'h26;
   localparam logic [7:0] ADDR_WDAY = 8'h27;
   localparam logic [7:0] ADDR_TSEC = 8'h41;
   localparam logic [7:0] ADDR_TMIN = 8'h42;
   localparam logic [7:0] ADDR_THR  = 8'h43;

   localparam int CTRL_RUN_BIT   = 0;
   localparam int CTRL_HOLD_BIT  = 1;
   localparam int STAT_ALARM_BIT = 2;
   localparam int CTRL_ACLR_BIT  = 3;

   localparam bcd_t BCD_ZERO = 8'h00;
   localparam bcd_t SEC_MAX  = 8'h59;
   localparam bcd_t MIN_MAX  = 8'h59;
   localparam bcd_t HR_MAX   = 8'h23;
   localparam bcd_t DAY_MIN  = 8'h01;
   localparam bcd_t DAY_MAX  = 8'h31;
   localparam bcd_t MON_MIN  = 8'h01;
   localparam bcd_t MON_MAX  = 8'h12;
   localparam bcd_t YR_MAX   = 8'h99;
   localparam bcd_t WDAY_MIN = 8'h01;
   localparam bcd_t WDAY_MAX = 8'h07;

   function automatic logic bcd_valid(input bcd_t v);
      return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9);
   endfunction
endpackage

// File: rtl/rtc_bus_responder_bcd_field.sv
// rtl/rtc_bus_responder_bcd_field.sv - two-digit BCD up/down counter with min/max wrap, load, carry and borrow
module bcd_field
   import rtc_bus_pkg::*;
#(
   parameter bcd_t MIN = 8'h00,
   parameter bcd_t MAX = 8'h59
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       load_i,
   input  logic [7:0] load_val_i,
   input  logic       inc_i,
   input  logic       dec_i,
   output logic [7:0] val_o,
   output logic       carry_o,
   output logic       borrow_o
);
   bcd_t val_q, val_d;
   logic bad;

   // Out-of-range or non-BCD contents are treated as sitting at the limit.
   assign bad   = !bcd_valid(val_q) || (val_q > MAX);
   assign val_o = val_q;

   always_comb begin
      val_d    = val_q;
      carry_o  = 1'b0;
      borrow_o = 1'b0;
      if (load_i) begin
         val_d = load_val_i;
      end else if (inc_i) begin
         if (bad || val_q == MAX) begin
            val_d   = MIN;
            carry_o = 1'b1;
         end else if (val_q[3:0] == 4'd9) begin
            val_d = {val_q[7:4] + 4'd1, 4'd0};
         end else begin
            val_d = val_q + 8'd1;
         end
      end else if (dec_i) begin
         if (bad) begin
            val_d = MAX;
         end else if (val_q <= MIN) begin
            val_d    = MAX;
            borrow_o = 1'b1;
         end else if (val_q[3:0] == 4'd0) begin
            val_d = {val_q[7:4] - 4'd1, 4'd9};
         end else begin
            val_d = val_q - 8'd1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) val_q <= MIN;
      else       val_q <= val_d;
   end
endmodule

// File: rtl/rtc_bus_responder.sv
// rtl/rtc_bus_responder.sv - BCD real-time clock on a multiplexed 8-bit bus; countdown timer built only with RTC_RESPONDER_TIMER_EN
module rtc_bus_responder
   import rtc_bus_pkg::*;
#(
   parameter int TICK_DIV = 100000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cs,
   input  logic       a_d,
   input  logic       rd,
   input  logic       wr,
   inout  wire  [7:0] dato,
   output logic       irq
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic          wr_q;
   logic [7:0]    addr_q, addr_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          run_q, run_d, hold_q, hold_d, alarm_q, alarm_d;
   logic          tick, tick_en, wr_ev, data_we;
   logic [7:0]    rdata;
   bcd_t          sec, min, hr, day, mon, yr, wday;
   logic          c_sec, c_min, c_hr, c_day, c_mon;
   logic [1:0]    unused_carry;
   logic [6:0]    unused_borrow;
   logic          t_stop, t_expire;

   // A write lands on the rising edge of the wr strobe while selected.
   assign wr_ev   = !wr_q && wr && !cs;
   assign data_we = wr_ev && a_d;
   assign addr_d  = (wr_ev && !a_d) ? dato : addr_q;
   assign tick    = (presc_q == PW'(TICK_DIV - 1));
   assign presc_d = tick ? '0 : presc_q + PW'(1);
   assign tick_en = tick && !hold_q;

   bcd_field #(.MIN(BCD_ZERO), .MAX(SEC_MAX)) u_sec (.clk_i(clk), .rst_i(reset), .load_i(data_we && addr_q == ADDR_SEC), .load_val_i(dato), .inc_i(tick_en), .dec_i(1'b0), .val_o(sec), .carry_o(c_sec), .borrow_o(unused_borrow[0]));
   bcd_field #(.MIN(BCD_ZERO), .MAX(MIN_MAX)) u_min (.clk_i(clk), .rst_i(reset), .load_i(data_we && addr_q == ADDR_MIN), .load_val_i(dato), .inc_i(c_sec), .dec_i(1'b0), .val_o(min), .carry_o(c_min), .borrow_o(unused_borrow[1]));
   bcd_field #(.MIN(BCD_ZERO), .MAX(HR_MAX)) u_hr (.clk_i(clk), .rst_i(reset), .load_i(data_we && addr_q == ADDR_HR), .load_val_i(dato), .inc_i(c_min), .dec_i(1'b0), .val_o(hr), .carry_o(c_hr), .borrow_o(unused_borrow[2]));
   bcd_field #(.MIN(DAY_MIN), .MAX(DAY_MAX)) u_day (.clk_i(clk), .rst_i(reset), .load_i(data_we && addr_q == ADDR_DAY), .load_val_i(dato), .inc_i(c_hr), .dec_i(1'b0), .val_o(day), .carry_o(c_day), .borrow_o(unused_borrow[3]));
   bcd_field #(.MIN(MON_MIN), .MAX(MON_MAX)) u_mon (.clk_i(clk), .rst_i(reset), .load_i(data_we && addr_q == ADDR_MON), .load_val_i(dato), .inc_i(c_day), .dec_i(1'b0), .val_o(mon), .carry_o(c_mon), .borrow_o(unused_borrow[4]));
   bcd_field #(.MIN(BCD_ZERO), .MAX(YR_MAX)) u_yr (.clk_i(clk), .rst_i(reset), .load_i(data_we && addr_q == ADDR_YR), .load_val_i(dato), .inc_i(c_mon), .dec_i(1'b0), .val_o(yr), .carry_o(unused_carry[0]), .borrow_o(unused_borrow[5]));
   bcd_field #(.MIN(WDAY_MIN), .MAX(WDAY_MAX)) u_wday (.clk_i(clk), .rst_i(reset), .load_i(data_we && addr_q == ADDR_WDAY), .load_val_i(dato), .inc_i(c_hr), .dec_i(1'b0), .val_o(wday), .carry_o(unused_carry[1]), .borrow_o(unused_borrow[6]));

`ifdef RTC_RESPONDER_TIMER_EN
   bcd_t       tsec, tmin, thr;
   logic       b_tsec, b_tmin, t_zero, t_dec;
   logic [2:0] unused_tcarry;
   logic       unused_tborrow;

   assign t_zero   = (tsec == BCD_ZERO) && (tmin == BCD_ZERO) && (thr == BCD_ZERO);
   assign t_dec    = tick && run_q && !t_zero;
   assign t_expire = t_dec && (tsec == 8'h01) && (tmin == BCD_ZERO) && (thr == BCD_ZERO);
   assign t_stop   = tick && run_q && (t_zero || t_expire);

   bcd_field #(.MIN(BCD_ZERO), .MAX(SEC_MAX)) u_tsec (.clk_i(clk), .rst_i(reset), .load_i(data_we && addr_q == ADDR_TSEC), .load_val_i(dato), .inc_i(1'b0), .dec_i(t_dec), .val_o(tsec), .carry_o(unused_tcarry[0]), .borrow_o(b_tsec));
   bcd_field #(.MIN(BCD_ZERO), .MAX(MIN_MAX)) u_tmin (.clk_i(clk), .rst_i(reset), .load_i(data_we && addr_q == ADDR_TMIN), .load_val_i(dato), .inc_i(1'b0), .dec_i(b_tsec), .val_o(tmin), .carry_o(unused_tcarry[1]), .borrow_o(b_tmin));
   bcd_field #(.MIN(BCD_ZERO), .MAX(HR_MAX)) u_thr (.clk_i(clk), .rst_i(reset), .load_i(data_we && addr_q == ADDR_THR), .load_val_i(dato), .inc_i(1'b0), .dec_i(b_tmin), .val_o(thr), .carry_o(unused_tcarry[2]), .borrow_o(unused_tborrow));
`else
   assign t_stop   = 1'b0;
   assign t_expire = 1'b0;
`endif

   // Bus write beats the auto-clear of run; alarm clear beats alarm set.
   always_comb begin
      run_d   = run_q;
      hold_d  = hold_q;
      alarm_d = alarm_q;
      if (t_stop)   run_d   = 1'b0;
      if (t_expire) alarm_d = 1'b1;
      if (data_we && addr_q == ADDR_CTRL) begin
         run_d  = dato[CTRL_RUN_BIT];
         hold_d = dato[CTRL_HOLD_BIT];
         if (dato[CTRL_ACLR_BIT]) alarm_d = 1'b0;
      end
`ifndef RTC_RESPONDER_TIMER_EN
      run_d   = 1'b0;
      alarm_d = 1'b0;
`endif
   end

   always_comb begin
      rdata = 8'h00;
      case (addr_q)
         ADDR_CTRL: begin
            rdata[CTRL_RUN_BIT]   = run_q;
            rdata[CTRL_HOLD_BIT]  = hold_q;
            rdata[STAT_ALARM_BIT] = alarm_q;
         end
         ADDR_SEC:  rdata = sec;
         ADDR_MIN:  rdata = min;
         ADDR_HR:   rdata = hr;
         ADDR_DAY:  rdata = day;
         ADDR_MON:  rdata = mon;
         ADDR_YR:   rdata = yr;
         ADDR_WDAY: rdata = wday;
`ifdef RTC_RESPONDER_TIMER_EN
         ADDR_TSEC: rdata = tsec;
         ADDR_TMIN: rdata = tmin;
         ADDR_THR:  rdata = thr;
`endif
         default:   rdata = 8'h00;
      endcase
   end

   assign dato = (!cs && !rd && a_d) ? rdata : 8'hzz;
   assign irq  = alarm_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q    <= 1'b1;
         addr_q  <= 8'h00;
         presc_q <= '0;
         run_q   <= 1'b0;
         hold_q  <= 1'b0;
         alarm_q <= 1'b0;
      end else begin
         wr_q    <= wr;
         addr_q  <= addr_d;
         presc_q <= presc_d;
         run_q   <= run_d;
         hold_q  <= hold_d;
         alarm_q <= alarm_d;
      end
   end
endmodule

// File: tb/tb_rtc_bus_responder.sv
// tb/tb_rtc_bus_responder.sv - scoreboard bench for rtc_bus_responder with a short tick divider
module tb_rtc_bus_responder;
   localparam int TD = 64;

   logic       clk = 1'b0;
   logic       reset, cs, a_d, rd, wr, irq;
   logic       tb_oe;
   logic [7:0] tb_dat;
   wire  [7:0] dato;
   int         edge_cnt;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   string      tag_q[$];

   assign dato = tb_oe ? tb_dat : 8'hzz;
   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup (dato[g]);
   end

   rtc_bus_responder #(.TICK_DIV(TD)) dut (
      .clk(clk), .reset(reset), .cs(cs), .a_d(a_d), .rd(rd), .wr(wr), .dato(dato), .irq(irq)
   );

   always #5 clk = ~clk;

   // Ticks land on edges where edge_cnt becomes a multiple of TD.
   always @(posedge clk) begin
      if (reset) edge_cnt <= 0;
      else       edge_cnt <= edge_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_phase(input logic ad, input logic [7:0] val);
      @(negedge clk); cs = 1'b0; a_d = ad; tb_oe = 1'b1; tb_dat = val; wr = 1'b0;
      @(negedge clk); wr = 1'b1;
      @(negedge clk); cs = 1'b1; tb_oe = 1'b0;
   endtask

   task automatic wr_reg(input logic [7:0] addr, input logic [7:0] val);
      bus_phase(1'b0, addr);
      bus_phase(1'b1, val);
   endtask

   task automatic wr_at_tick(input logic [7:0] addr, input logic [7:0] val);
      bus_phase(1'b0, addr);
      @(negedge clk); cs = 1'b0; a_d = 1'b1; tb_oe = 1'b1; tb_dat = val; wr = 1'b0;
      do @(negedge clk); while ((edge_cnt + 1) % TD != 0);
      wr = 1'b1;
      @(negedge clk); cs = 1'b1; tb_oe = 1'b0;
   endtask

   task automatic rd_reg(input string tag, input logic [7:0] addr, input logic [7:0] exp);
      bus_phase(1'b0, addr);
      @(negedge clk); cs = 1'b0; a_d = 1'b1; rd = 1'b0;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      #2;
      check_val(tag_q.pop_front(), dato, exp_q.pop_front());
      @(negedge clk); rd = 1'b1; cs = 1'b1;
   endtask

   task automatic wait_tick();
      do @(negedge clk); while (edge_cnt % TD != 0);
   endtask

   initial begin
      reset = 1'b1; cs = 1'b1; a_d = 1'b0; rd = 1'b1; wr = 1'b1; tb_oe = 1'b0; tb_dat = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #2;
      check_val("rst_hiz", dato, 8'hFF);
      check_val("rst_irq", {7'b0, irq}, 8'h00);
      rd_reg("rst_sec", 8'h21, 8'h00);
      rd_reg("rst_day", 8'h24, 8'h01);
      rd_reg("rst_mon", 8'h25, 8'h01);
      rd_reg("rst_yr", 8'h26, 8'h00);
      rd_reg("rst_wday", 8'h27, 8'h01);
      rd_reg("rst_ctrl", 8'h00, 8'h00);
      rd_reg("rst_tsec", 8'h41, 8'h00);

      // Midnight rollover
      wr_reg(8'h00, 8'h02);
      wr_reg(8'h21, 8'h59);
      wr_reg(8'h22, 8'h59);
      wr_reg(8'h23, 8'h23);
      wr_reg(8'h00, 8'h00);
      wait_tick();
      rd_reg("roll_sec", 8'h21, 8'h00);
      rd_reg("roll_min", 8'h22, 8'h00);
      rd_reg("roll_hr", 8'h23, 8'h00);
      rd_reg("roll_day", 8'h24, 8'h02);
      rd_reg("roll_wday", 8'h27, 8'h02);

      // Plain write/read and tri-state behaviour
      wr_reg(8'h23, 8'h12);
      rd_reg("hr_wr", 8'h23, 8'h12);
      @(negedge clk); cs = 1'b0; a_d = 1'b1; rd = 1'b1;
      #2; check_val("hiz_rd1", dato, 8'hFF);
      @(negedge clk); wr = 1'b0;
      #2; check_val("hiz_rd1_wr0", dato, 8'hFF);
      @(negedge clk); cs = 1'b1; wr = 1'b1;
      rd_reg("hr_keep", 8'h23, 8'h12);
      rd_reg("unmapped", 8'h30, 8'h00);

      // Bus write coincident with a tick
      wr_at_tick(8'h21, 8'h30);
      rd_reg("wr_vs_tick", 8'h21, 8'h30);

      // Hold, then an invalid BCD seconds value
      wr_reg(8'h00, 8'h02);
      wr_reg(8'h21, 8'h15);
      wr_reg(8'h22, 8'h07);
      repeat (3) wait_tick();
      rd_reg("hold_sec", 8'h21, 8'h15);
      rd_reg("hold_ctrl", 8'h00, 8'h02);
      wr_reg(8'h21, 8'h4A);
      wr_reg(8'h00, 8'h00);
      wait_tick();
      rd_reg("bad_sec", 8'h21, 8'h00);
      rd_reg("bad_min", 8'h22, 8'h08);

      // New-year rollover of every date field
      wr_reg(8'h00, 8'h02);
      wr_reg(8'h21, 8'h59);
      wr_reg(8'h22, 8'h59);
      wr_reg(8'h23, 8'h23);
      wr_reg(8'h24, 8'h31);
      wr_reg(8'h25, 8'h12);
      wr_reg(8'h26, 8'h99);
      wr_reg(8'h27, 8'h07);
      wr_reg(8'h00, 8'h00);
      wait_tick();
      rd_reg("ny_hr", 8'h23, 8'h00);
      rd_reg("ny_day", 8'h24, 8'h01);
      rd_reg("ny_mon", 8'h25, 8'h01);
      rd_reg("ny_yr", 8'h26, 8'h00);
      rd_reg("ny_wday", 8'h27, 8'h01);

`ifdef RTC_RESPONDER_TIMER_EN
      wr_reg(8'h41, 8'h02);
      wr_reg(8'h42, 8'h00);
      wr_reg(8'h43, 8'h00);
      wr_reg(8'h00, 8'h01);
      wait_tick();
      check_val("tmr_irq_1", {7'b0, irq}, 8'h00);
      wait_tick();
      check_val("tmr_irq_2", {7'b0, irq}, 8'h01);
      rd_reg("tmr_stat", 8'h00, 8'h04);
      wr_reg(8'h00, 8'h08);
      check_val("tmr_clr", {7'b0, irq}, 8'h00);
      wr_reg(8'h00, 8'h01);
      wait_tick();
      rd_reg("tmr_zero_run", 8'h00, 8'h00);
      check_val("tmr_zero_irq", {7'b0, irq}, 8'h00);
      wr_reg(8'h41, 8'h00);
      wr_reg(8'h42, 8'h01);
      wr_reg(8'h00, 8'h01);
      wait_tick();
      rd_reg("tmr_bor_sec", 8'h41, 8'h59);
      rd_reg("tmr_bor_min", 8'h42, 8'h00);
`else
      wr_reg(8'h41, 8'h05);
      rd_reg("notmr_tsec", 8'h41, 8'h00);
      wr_reg(8'h00, 8'h01);
      rd_reg("notmr_ctrl", 8'h00, 8'h00);
      repeat (2) wait_tick();
      check_val("notmr_irq", {7'b0, irq}, 8'h00);
`endif

      // Reset in the middle of a data phase
      wr_reg(8'h00, 8'h02);
      wr_reg(8'h22, 8'h44);
      rd_reg("pre_rst_min", 8'h22, 8'h44);
      bus_phase(1'b0, 8'h22);
      @(negedge clk); cs = 1'b0; a_d = 1'b1; tb_oe = 1'b1; tb_dat = 8'h33; wr = 1'b0;
      @(negedge clk); reset = 1'b1;
      @(negedge clk); wr = 1'b1; cs = 1'b1; tb_oe = 1'b0;
      @(negedge clk); reset = 1'b0;
      rd_reg("abort_min", 8'h22, 8'h00);
      rd_reg("abort_ctrl", 8'h00, 8'h00);
      check_val("abort_irq", {7'b0, irq}, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rtc_bus_responder.md
RTC_BUS_RESPONDER -- requirements
Module: rtc_bus_responder

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000; clk cycles per 1 s time-keeping tick.
REQ-002 SHALL have port clk, input, 1; single system clock, all logic on rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port cs, input, 1; chip select, active-low.
REQ-005 SHALL have port a_d, input, 1; 0 = address phase, 1 = data phase.
REQ-006 SHALL have port rd, input, 1; read strobe, active-low.
REQ-007 SHALL have port wr, input, 1; write strobe, active-low.
REQ-008 SHALL have port dato, inout, 8; multiplexed address/data bus.
REQ-009 SHALL have port irq, output, 1; timer alarm flag, active-high.

Function
REQ-010 SHALL implement register map:
- 0x00 control/status
- 0x21 seconds, 0x22 minutes, 0x23 hours (BCD, 24 h)
- 0x24 day, 0x25 month, 0x26 year, 0x27 weekday
- 0x41/0x42/0x43 timer sec/min/hours (BCD)
REQ-011 SHALL register wr each cycle; write event = previous-cycle wr=0, current wr=1, cs=0.
REQ-012 SHALL latch dato into address register on write event with a_d=0.
REQ-013 SHALL commit dato into the addressed register on write event with a_d=1; visible on the next cycle; unmapped addresses ignored.
REQ-014 SHALL drive dato combinationally with the addressed register when cs=0, rd=0, a_d=1; high-Z otherwise; unmapped reads return 0x00.
REQ-015 SHALL never drive dato when rd=1 or cs=1, including while wr=0.
REQ-016 SHALL generate a one-cycle tick when prescaler reaches TICK_DIV-1, then reload 0.
REQ-017 SHALL, on tick with control bit1 (hold)=0, increment seconds 00..59 -> minutes 00..59 -> hours 00..23 -> day 01..31 -> month 01..12 -> year 00..99; weekday 01..07 increments on hour wrap.
REQ-018 SHALL wrap any field whose stored value is at or beyond its limit (incl. invalid BCD) to its minimum and carry.
REQ-019 SHALL count the timer down by one second per tick while control bit0 (run)=1 and timer is nonzero.
REQ-020 SHALL, when a decrement reaches 00:00:00, set alarm flag (status bit2) and clear run in the same cycle.
REQ-021 SHALL hold a timer already at 00:00:00 with run=1: clear run, do not set alarm.
REQ-022 SHALL let a bus write win over tick update of the same register in the same cycle; other fields still update.
REQ-023 SHALL clear alarm flag on write to 0x00 with bit3=1; clear wins over simultaneous set.
REQ-024 SHALL read 0x00 as {5'b0, alarm, hold, run}; irq equals alarm flag.

Reset
REQ-025 SHALL, on reset, set time 00:00:00, date 01/01/00, weekday 01, timer 00:00:00, control 0x00, alarm 0, prescaler 0, address 0x00, irq 0, dato high-Z.
REQ-026 SHALL abort any bus cycle in progress on reset; no partial write commits.

Configuration
REQ-027 SHALL compile timer logic only when macro RTC_RESPONDER_TIMER_EN is defined.
REQ-028 SHALL, without RTC_RESPONDER_TIMER_EN, treat 0x41-0x43 as unmapped, hold run/alarm at 0, irq constant 0.

Structure
REQ-029 SHALL place register addresses, control bit indices and field limits in package rtc_bus_pkg.
REQ-030 SHALL use sub-module bcd_field (two-digit BCD up/down counter with min/max, load, carry/borrow) for every time, date and timer field.

Verification
REQ-031 SHALL check: reset, then write 0x59 to 0x21, 0x59 to 0x22, 0x23 to 0x23; one tick -> read 0x00 at 0x21/0x22/0x23, day 0x02, weekday 0x02.
REQ-032 SHALL check: write addr 0x23 then data 0x12; read 0x23 -> 0x12; dato high-Z whenever rd=1.
REQ-033 SHALL check: timer 00:00:02, control 0x01; two ticks -> irq=1, status reads 0x04; write 0x08 to 0x00 -> irq=0.
REQ-034 SHALL check: seconds write event coincident with tick -> written value retained, no increment.
REQ-035 SHALL check: control 0x02 (hold) for three ticks -> seconds unchanged; write 0x4A to 0x21, tick -> seconds 0x00, minutes +1.
REQ-036 SHALL check: reset asserted mid data phase with wr=0 -> target register reads reset value after release.
